spi_peripheral: RTL

SPI target (peripheral) end of the link driven by spi_controller. It is used as a loopback/bring-up partner in the same fabric and as an on-chip register-access target. SCLK, CS and MOSI are oversampled in the CLK domain. MOSI bits are shifted into an MSB-aligned 64-bit receive word, and a 64-bit transmit word is shifted out on MISO. It supports all four CPOL/CPHA modes and per-frame bit widths, matching the controller's DIN/DOUT alignment.

---
 rtl/spi_peripheral.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// SPI target: oversamples CS/SCLK/MOSI in the CLK domain, shifts MSB-first on both lines,
// supports all CPOL/CPHA modes and per-frame widths; RX word is left-justified at bit 63.
`timescale 1ns/1ps
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic [7:0]  MOSI_WIDTH,
  input  logic [7:0]  MISO_WIDTH,
  input  logic [63:0] TX_DATA,
  output logic [63:0] RX_DATA,
  output logic [6:0]  RX_BITS,
  output logic        RX_VALID,
  output logic        BUSY,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic sclk_prev;
  logic cs_s, sclk_s, mosi_s;

  logic        cpol_reg, cpha_reg;
  logic [6:0]  mosi_w_reg, miso_w_reg;
  logic [63:0] tx_shift, rx_shift;
  logic [6:0]  rx_cnt, tx_cnt;
  logic [6:0]  mosi_w_clamp, miso_w_clamp;

  logic lead_edge, trail_edge;
  logic start, finish, rx_sample, tx_step;

  // CS synchronizer resets to "asserted" so a frame in flight at reset release is skipped
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge  = (sclk_s != sclk_prev) && (sclk_s != cpol_reg);
  assign trail_edge = (sclk_s != sclk_prev) && (sclk_s == cpol_reg);

  assign mosi_w_clamp = (MOSI_WIDTH > 8'd64) ? 7'd64 : MOSI_WIDTH[6:0];
  assign miso_w_clamp = (MISO_WIDTH > 8'd64) ? 7'd64 : MISO_WIDTH[6:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= WAIT_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (cs_s)  state_next = IDLE;
      IDLE:      if (!cs_s) state_next = ACTIVE;
      ACTIVE:    if (cs_s)  state_next = IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  // CS rising wins over a coincident SCLK edge
  always_comb begin
    start     = (state == IDLE) && !cs_s;
    finish    = (state == ACTIVE) && cs_s;
    rx_sample = (state == ACTIVE) && !cs_s && (cpha_reg ? trail_edge : lead_edge)
                && (rx_cnt < mosi_w_reg);
    tx_step   = (state == ACTIVE) && !cs_s && (cpha_reg ? lead_edge : trail_edge);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cpol_reg   <= 1'b0;
      cpha_reg   <= 1'b0;
      mosi_w_reg <= '0;
      miso_w_reg <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      RX_DATA    <= '0;
      RX_BITS    <= '0;
      RX_VALID   <= 1'b0;
      BUSY       <= 1'b0;
      MISO       <= 1'b0;
      MISO_OE    <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      if (start) begin
        cpol_reg   <= CPOL;
        cpha_reg   <= CPHA;
        mosi_w_reg <= mosi_w_clamp;
        miso_w_reg <= miso_w_clamp;
        tx_shift   <= TX_DATA;
        rx_shift   <= '0;
        rx_cnt     <= '0;
        tx_cnt     <= '0;
        BUSY       <= 1'b1;
        MISO_OE    <= 1'b1;
        MISO       <= (!CPHA && (miso_w_clamp != 7'd0)) ? TX_DATA[63] : 1'b0;
      end else if (finish) begin
        RX_DATA  <= rx_shift << (7'd64 - rx_cnt);
        RX_BITS  <= rx_cnt;
        RX_VALID <= 1'b1;
        BUSY     <= 1'b0;
        MISO_OE  <= 1'b0;
        MISO     <= 1'b0;
      end else begin
        if (rx_sample) begin
          rx_shift <= {rx_shift[62:0], mosi_s};
          rx_cnt   <= rx_cnt + 7'd1;
        end
        if (tx_step) begin
          if (tx_cnt < miso_w_reg) begin
            tx_shift <= tx_shift << 1;
            tx_cnt   <= tx_cnt + 7'd1;
            if (cpha_reg) MISO <= tx_shift[63];
            else          MISO <= ((tx_cnt + 7'd1) < miso_w_reg) ? tx_shift[62] : 1'b0;
          end else begin
            MISO <= 1'b0;
          end
        end
      end
    end
  end

endmodule
